// File: rtl/uc_cuenta_n.sv
// rtl/uc_cuenta_n.sv - ones-counting control unit (optional feature macro: UC_EARLY_EXIT_EN)
module uc_cuenta_n #(
    parameter int N = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic qzero,
    output logic CargaQ,
    output logic DesplazaQ,
    output logic ResetA,
    output logic CargaA,
    output logic fin,
    output logic busy
);

    localparam int IW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] it_q, it_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            it_q    <= '0;
        end else begin
            state_q <= state_d;
            it_q    <= it_d;
        end
    end

    always_comb begin
        state_d = state_q;
        it_d    = it_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                it_d    = IW'(N);
                state_d = RUN;
            end
            RUN: begin
                it_d = it_q - IW'(1);
                if (it_q == IW'(1)) state_d = DONE;
`ifdef UC_EARLY_EXIT_EN
                // Remaining Q bits are all zero: nothing left to count.
                if (qzero) begin
                    it_d    = '0;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                // A new operation requires start to drop first.
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        CargaQ    = 1'b0;
        DesplazaQ = 1'b0;
        ResetA    = 1'b0;
        CargaA    = 1'b0;
        fin       = 1'b0;
        busy      = 1'b0;
        case (state_q)
            LOAD: begin
                CargaQ = 1'b1;
                ResetA = 1'b1;
                busy   = 1'b1;
            end
            RUN: begin
                busy      = 1'b1;
                DesplazaQ = 1'b1;
                CargaA    = q0;
`ifdef UC_EARLY_EXIT_EN
                if (qzero) begin
                    DesplazaQ = 1'b0;
                    CargaA    = 1'b0;
                end
`endif
            end
            DONE: fin = 1'b1;
            default: ;
        endcase
    end

`ifndef UC_EARLY_EXIT_EN
    logic unused_qzero;
    assign unused_qzero = qzero;
`endif

endmodule

// File: tb/tb_uc_cuenta_n.sv
// tb/tb_uc_cuenta_n.sv - randomized self-checking bench for uc_cuenta_n (N=3 and N=8)
module tb_uc_cuenta_n;

`ifdef UC_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start3, start8;
    logic [2:0] valor3;
    logic [7:0] valor8;
    logic [2:0] q3;
    logic [7:0] q8;
    logic [7:0] a3, a8;

    logic cq3, dq3, ra3, ca3, fin3, busy3;
    logic cq8, dq8, ra8, ca8, fin8, busy8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uc_cuenta_n #(.N(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .q0(q3[0]), .qzero(q3 == 3'd0),
        .CargaQ(cq3), .DesplazaQ(dq3), .ResetA(ra3), .CargaA(ca3), .fin(fin3), .busy(busy3)
    );

    uc_cuenta_n #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .q0(q8[0]), .qzero(q8 == 8'd0),
        .CargaQ(cq8), .DesplazaQ(dq8), .ResetA(ra8), .CargaA(ca8), .fin(fin8), .busy(busy8)
    );

    // Datapath the control unit sequences: Q shift register and A counter.
    always @(posedge clk) begin
        if (cq3) q3 <= valor3; else if (dq3) q3 <= q3 >> 1;
        if (ra3) a3 <= 8'd0;   else if (ca3) a3 <= a3 + 8'd1;
        if (cq8) q8 <= valor8; else if (dq8) q8 <= q8 >> 1;
        if (ra8) a8 <= 8'd0;   else if (ca8) a8 <= a8 + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] obs(input int sel);
        if (sel == 0) return {cq3, dq3, ra3, ca3, fin3, busy3};
        return {cq8, dq8, ra8, ca8, fin8, busy8};
    endfunction

    task automatic set_start(input int sel, input logic b);
        if (sel == 0) start3 = b; else start8 = b;
    endtask

    // Expected {CargaQ,DesplazaQ,ResetA,CargaA,fin,busy} in cycle k after the start sample.
    function automatic logic [5:0] exp_vec(input logic [7:0] v, input int k, input int fk, input int r);
        int j;
        if (k == 1)  return 6'b101001;
        if (k == fk) return 6'b000010;
        j = k - 2;
        if (!EARLY || j < r) return {1'b0, 1'b1, 1'b0, v[j], 1'b0, 1'b1};
        return 6'b000001;
    endfunction

    task automatic run_op(input int sel, input logic [7:0] vin, input bit wiggle, input int hold);
        int nn, r, fk;
        logic [7:0] v;
        nn = (sel == 0) ? 3 : 8;
        v  = (sel == 0) ? (vin & 8'h07) : vin;
        r  = 0;
        for (int i = 0; i < nn; i++) if (v[i]) r = i + 1;
        fk = nn + 2;
        if (EARLY && r + 3 < fk) fk = r + 3;
        if (sel == 0) valor3 = v[2:0]; else valor8 = v;
        set_start(sel, 1'b1);
        for (int k = 1; k <= fk; k++) begin
            @(posedge clk); #1;
            chk($sformatf("n%0d v=%0h cyc%0d", nn, v, k), 32'(obs(sel)), 32'(exp_vec(v, k, fk, r)));
            if (wiggle && k < fk) set_start(sel, 1'($urandom_range(0, 1)));
            if (k == fk) set_start(sel, 1'b1);
        end
        chk($sformatf("n%0d v=%0h A", nn, v), 32'((sel == 0) ? a3 : a8), 32'($countones(v)));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk($sformatf("n%0d hold%0d", nn, h), 32'(obs(sel)), 32'(6'b000010));
        end
        set_start(sel, 1'b0);
        @(posedge clk); #1;
        chk($sformatf("n%0d idle", nn), 32'(obs(sel)), 32'(6'b000000));
    endtask

    initial begin
        reset = 1'b1; start3 = 1'b0; start8 = 1'b0; valor3 = '0; valor8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset n3", 32'(obs(0)), 32'(6'b0));
        chk("reset n8", 32'(obs(1)), 32'(6'b0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle n3", 32'(obs(0)), 32'(6'b0));

        run_op(0, 8'h05, 1'b0, 1);
        run_op(0, 8'h07, 1'b0, 0);
        run_op(0, 8'h00, 1'b0, 0);
        run_op(0, 8'h01, 1'b0, 0);
        run_op(0, 8'h06, 1'b1, 2);
        run_op(1, 8'hA5, 1'b0, 0);
        run_op(1, 8'hFF, 1'b1, 1);

        // Reset in the second RUN cycle with start held high.
        valor3 = 3'b110; start3 = 1'b1;
        @(posedge clk); #1; chk("rst load", 32'(obs(0)), 32'(6'b101001));
        @(posedge clk); #1; chk("rst run1", 32'(obs(0)), 32'(6'b010001));
        @(posedge clk); #1; chk("rst run2", 32'(obs(0)), 32'(6'b010101));
        reset = 1'b1;
        @(posedge clk); #1; chk("rst abort", 32'(obs(0)), 32'(6'b0));
        reset = 1'b0;
        @(posedge clk); #1; chk("rst reload", 32'(obs(0)), 32'(6'b101001));
        reset = 1'b1; start3 = 1'b0;
        @(posedge clk); #1; chk("rst abort2", 32'(obs(0)), 32'(6'b0));
        reset = 1'b0;
        @(posedge clk); #1; chk("rst idle", 32'(obs(0)), 32'(6'b0));

        for (int n = 0; n < 24; n++) begin
            run_op($urandom_range(0, 1), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
